// File: rtl/boot_loader.sv
// Serial boot loader: frames a UART byte stream (sync, length, payload, checksum)
// and writes the payload into RAM through the MMU boot path while holding the CPU in reset.
`ifndef RESET_VECTOR
`define RESET_VECTOR 16'h0000
`endif

module boot_loader #(
    parameter logic [15:0] LOAD_BASE = `RESET_VECTOR,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [23:0] TIMEOUT   = 24'd5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        booting,
    output logic [7:0]  boot_data,
    output logic [15:0] boot_addr,
    output logic        boot_we,
    output logic        cpu_reset,
    output logic        boot_done,
    output logic        boot_error
);

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 16;
    localparam int unsigned IW = 17;
    localparam int unsigned TW = 24;

    // Largest payload that still fits between LOAD_BASE and the top of the address space.
    localparam logic [IW-1:0] MAX_LEN = 17'h1_0000 - IW'(LOAD_BASE);

    typedef enum logic [2:0] {
        S_SYNC,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   len_q, len_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [DW-1:0]   sum_q, sum_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [DW-1:0]   data_q, data_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    logic            booting_q, booting_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [AW-1:0]   len_full;
    logic [DW-1:0]   csum;
    logic            timed;

    assign len_full = {rx_data, len_q[DW-1:0]};
    assign csum     = DW'(sum_q + rx_data);
    assign timed    = state_q inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_SYNC;
            len_q     <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
            tmo_q     <= '0;
            data_q    <= '0;
            addr_q    <= LOAD_BASE;
            we_q      <= 1'b0;
            booting_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            tmo_q     <= tmo_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            booting_q <= booting_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        tmo_d     = tmo_q;
        data_d    = data_q;
        addr_d    = addr_q;
        we_d      = 1'b0;
        booting_d = booting_q;
        done_d    = done_q;
        err_d     = err_q;

        if (rx_valid) begin
            // A byte always wins over an expiring timeout in the same cycle.
            tmo_d = '0;
            unique case (state_q)
                S_SYNC: begin
                    if (rx_data == SYNC_BYTE) state_d = S_LEN_LO;
                end
                S_LEN_LO: begin
                    len_d   = {len_q[AW-1:DW], rx_data};
                    state_d = S_LEN_HI;
                end
                S_LEN_HI: begin
                    len_d = len_full;
                    idx_d = '0;
                    sum_d = '0;
                    if (IW'(len_full) > MAX_LEN) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end else if (len_full == '0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    data_d = rx_data;
                    addr_d = AW'(LOAD_BASE + idx_q[AW-1:0]);
                    we_d   = 1'b1;
                    sum_d  = csum;
                    idx_d  = IW'(idx_q + IW'(1));
                    if (idx_q == IW'(IW'(len_q) - IW'(1))) state_d = S_CSUM;
                end
                S_CSUM: begin
                    if (csum == '0) begin
                        state_d   = S_DONE;
                        booting_d = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (timed && (TIMEOUT != '0)) begin
            if (tmo_q == TW'(TIMEOUT - TW'(1))) begin
                state_d = S_ERROR;
                err_d   = 1'b1;
                tmo_d   = '0;
            end else begin
                tmo_d = TW'(tmo_q + TW'(1));
            end
        end
    end

    assign booting    = booting_q;
    assign cpu_reset  = booting_q;
    assign boot_data  = data_q;
    assign boot_addr  = addr_q;
    assign boot_we    = we_q;
    assign boot_done  = done_q;
    assign boot_error = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: expected RAM writes are queued as bytes are sent
// and matched against every observed boot_we pulse.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;

    logic        booting, boot_we, cpu_reset, boot_done, boot_error;
    logic [7:0]  boot_data;
    logic [15:0] boot_addr;

    logic        hi_booting, hi_we, hi_cpu_reset, hi_done, hi_error;
    logic [7:0]  hi_data;
    logic [15:0] hi_addr;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t exp_q[$];
    int  n_pass  = 0;
    int  n_total = 0;

    always #5 clk = ~clk;

    boot_loader #(.LOAD_BASE(16'h0400), .SYNC_BYTE(8'hA5), .TIMEOUT(24'd100)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .booting(booting), .boot_data(boot_data), .boot_addr(boot_addr),
        .boot_we(boot_we), .cpu_reset(cpu_reset), .boot_done(boot_done),
        .boot_error(boot_error)
    );

    boot_loader #(.LOAD_BASE(16'hFF00), .SYNC_BYTE(8'hA5), .TIMEOUT(24'd100)) dut_hi (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .booting(hi_booting), .boot_data(hi_data), .boot_addr(hi_addr),
        .boot_we(hi_we), .cpu_reset(hi_cpu_reset), .boot_done(hi_done),
        .boot_error(hi_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // One clock; outputs sampled 1 time unit after the edge and any write scored.
    task automatic tick();
        wr_t w;
        @(posedge clk);
        #1;
        if (boot_we !== 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(boot_we), 32'd0);
            end else begin
                w = exp_q.pop_front();
                chk("write_addr", 32'(boot_addr), 32'(w.addr));
                chk("write_data", 32'(boot_data), 32'(w.data));
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic check_queue_empty(input string tag);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_nominal(input string tag);
        expect_wr(16'h0400, 8'h11);
        expect_wr(16'h0401, 8'h22);
        expect_wr(16'h0402, 8'h33);
        send(8'hA5); send(8'h03); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33);
        chk({tag, "_booting_before_csum"}, 32'(booting), 32'd1);
        send(8'h9A);
        chk({tag, "_done"}, 32'(boot_done), 32'd1);
        chk({tag, "_booting"}, 32'(booting), 32'd0);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
        chk({tag, "_error"}, 32'(boot_error), 32'd0);
        check_queue_empty({tag, "_writes"});
    endtask

    initial begin
        // Reset values
        tick();
        chk("rst_booting", 32'(booting), 32'd1);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_we", 32'(boot_we), 32'd0);
        chk("rst_data", 32'(boot_data), 32'd0);
        chk("rst_addr", 32'(boot_addr), 32'h0400);
        chk("rst_done", 32'(boot_done), 32'd0);
        chk("rst_error", 32'(boot_error), 32'd0);
        rst = 1'b0;
        tick();

        // Nominal load, then trailing bytes are ignored
        run_nominal("nominal");
        idle(2);
        chk("hold_data", 32'(boot_data), 32'h33);
        chk("hold_addr", 32'(boot_addr), 32'h0402);
        send(8'hA5); send(8'h01); send(8'h00); send(8'h55); send(8'hAB);
        chk("done_sticky", 32'(boot_done), 32'd1);

        // Garbage before sync
        do_reset();
        send(8'h00); send(8'hFF); send(8'h5A);
        chk("garbage_no_sync", 32'(booting), 32'd1);
        run_nominal("garbage");

        // Bad checksum
        do_reset();
        expect_wr(16'h0400, 8'h7F);
        send(8'hA5); send(8'h01); send(8'h00); send(8'h7F); send(8'h00);
        chk("badcs_error", 32'(boot_error), 32'd1);
        chk("badcs_booting", 32'(booting), 32'd1);
        chk("badcs_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("badcs_done", 32'(boot_done), 32'd0);
        send(8'hA5); send(8'h01); send(8'h00); send(8'h44); send(8'hBC);
        chk("badcs_error_sticky", 32'(boot_error), 32'd1);
        check_queue_empty("badcs_writes");

        // Zero length
        do_reset();
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
        chk("zero_done", 32'(boot_done), 32'd1);
        chk("zero_booting", 32'(booting), 32'd0);

        // Overflow with LOAD_BASE=FF00: 0x101 overflows, 0x100 fits exactly
        do_reset();
        send(8'hA5); send(8'h01);
        chk("ovf_before_hi", 32'(hi_error), 32'd0);
        send(8'h01);
        chk("ovf_error", 32'(hi_error), 32'd1);
        chk("ovf_booting", 32'(hi_booting), 32'd1);
        do_reset();
        send(8'hA5); send(8'h00); send(8'h01);
        chk("ovf_boundary_ok", 32'(hi_error), 32'd0);

        // Timeout: 100 idle clocks expire
        do_reset();
        expect_wr(16'h0400, 8'h11);
        send(8'hA5); send(8'h02); send(8'h00); send(8'h11);
        idle(99);
        chk("tmo_not_yet", 32'(boot_error), 32'd0);
        idle(1);
        chk("tmo_error", 32'(boot_error), 32'd1);
        chk("tmo_booting", 32'(booting), 32'd1);
        check_queue_empty("tmo_writes");

        // Byte on the expiry cycle wins
        do_reset();
        expect_wr(16'h0400, 8'h11);
        expect_wr(16'h0401, 8'h22);
        send(8'hA5); send(8'h02); send(8'h00); send(8'h11);
        idle(99);
        send(8'h22);
        chk("tmo_race_no_error", 32'(boot_error), 32'd0);
        send(8'hCD);
        chk("tmo_race_done", 32'(boot_done), 32'd1);
        check_queue_empty("tmo_race_writes");

        // 256 back-to-back payload bytes
        do_reset();
        for (int i = 0; i < 256; i++) expect_wr(16'(16'h0400 + i), 8'(i));
        send(8'hA5); send(8'h00); send(8'h01);
        for (int i = 0; i < 256; i++) send(8'(i));
        check_queue_empty("b2b_writes");
        send(8'h80);
        chk("b2b_done", 32'(boot_done), 32'd1);
        chk("b2b_error", 32'(boot_error), 32'd0);

        // Asynchronous reset mid-payload, then a fresh frame
        do_reset();
        for (int i = 0; i < 5; i++) expect_wr(16'(16'h0400 + i), 8'(8'h60 + i));
        send(8'hA5); send(8'h10); send(8'h00);
        for (int i = 0; i < 5; i++) send(8'(8'h60 + i));
        chk("mid_we_high", 32'(boot_we), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_we", 32'(boot_we), 32'd0);
        chk("mid_rst_addr", 32'(boot_addr), 32'h0400);
        chk("mid_rst_data", 32'(boot_data), 32'd0);
        chk("mid_rst_booting", 32'(booting), 32'd1);
        chk("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check_queue_empty("mid_writes");
        tick();
        rst = 1'b0;
        tick();
        run_nominal("fresh");

        check_queue_empty("final_writes");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
# boot_loader

Serial program loader that fills RAM before the CPU runs. It consumes a byte stream from the UART receiver and frames it as sync, length, payload and checksum. It writes each payload byte to RAM through the MMU's boot path (`booting`, `boot_data`) and holds the CPU in reset until the image is loaded and verified. It is the producer side of the MMU's boot-data interface; top level selects `boot_addr` onto the RAM address while `booting` is high.

## Interface
Parameters:
- `LOAD_BASE`, default `` `RESET_VECTOR ``: RAM address of payload byte 0.
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `TIMEOUT`, default 24'd5_000_000: maximum idle clocks between bytes inside a frame; 0 disables the timeout.

Ports:
- `clk` input 1: system clock; single clock domain.
- `rst` input 1: asynchronous, active-high reset.
- `rx_data` input 8: received byte; valid only when `rx_valid` is high.
- `rx_valid` input 1: one-cycle strobe per received byte.
- `booting` output 1: high while loading; drives the MMU `booting` input.
- `boot_data` output 8: byte to write; drives the MMU `boot_data` input.
- `boot_addr` output 16: RAM write address.
- `boot_we` output 1: one-cycle RAM write strobe.
- `cpu_reset` output 1: holds the CPU in reset; equals `booting`.
- `boot_done` output 1: sticky; the image was loaded and its checksum matched.
- `boot_error` output 1: sticky; checksum mismatch, length overflow or timeout.

## Operation
- States and transitions:
  - `SYNC`: wait for a byte equal to `SYNC_BYTE`; all other bytes are discarded. On a match, go to `LEN_LO`.
  - `LEN_LO`: latch `len[7:0]`; go to `LEN_HI`.
  - `LEN_HI`: latch `len[15:8]`.
    - Overflow check: if `len > 17'h10000 - LOAD_BASE`, go to `ERROR`.
    - If `len == 0`, go to `CSUM`.
    - Otherwise clear `idx` and `sum` and go to `DATA`.
  - `DATA`: for each byte:
    - Register `boot_data = rx_data` and `boot_addr = LOAD_BASE + idx` (16-bit add).
    - Pulse `boot_we`.
    - Update `sum += rx_data` (8-bit, wraps) and `idx += 1`.
    - When the last byte (`idx == len-1`) is accepted, go to `CSUM`.
  - `CSUM`: if `(sum + rx_data) & 8'hFF == 0`, go to `DONE`; otherwise go to `ERROR`.
  - `DONE`: `booting` low, `boot_done` high. All `rx_valid` are ignored until reset.
  - `ERROR`: `booting` stays high (CPU held), `boot_error` high. All `rx_valid` are ignored until reset.
- `idx` is 17 bits internally, so a full 64 KiB image does not wrap before the compare.
- The checksum is the two's complement of the 8-bit payload sum; for an empty payload the checksum byte must be 8'h00.
- The sync byte and length bytes are not included in the checksum.
- No back-pressure: every `rx_valid` byte is consumed in the cycle it arrives.

## Timing
- Reset values:
  - State `SYNC`.
  - `booting=1`, `cpu_reset=1`.
  - `boot_we=0`, `boot_data=0`, `boot_addr=LOAD_BASE`.
  - `boot_done=0`, `boot_error=0`.
  - `len=0`, `idx=0`, `sum=0`, timeout counter 0.
- All outputs are registered.
- Write latency: `boot_we`, `boot_data` and `boot_addr` update on the edge that samples `rx_valid`, so they are visible in the next cycle. `boot_we` is high for exactly one cycle per payload byte.
- `boot_data` and `boot_addr` hold their last values between writes.
- `booting` falls on the same edge that enters `DONE` (one cycle after the checksum strobe). RAM is quiescent at that point: the last write completes at least one cycle earlier.
- Timeout:
  - The counter runs only in `LEN_LO`, `LEN_HI`, `DATA` and `CSUM`, and clears on every `rx_valid`.
  - Reaching `TIMEOUT` enters `ERROR`.
  - If `rx_valid` arrives in the same cycle the counter expires, `rx_valid` wins: the byte is processed and the counter clears.
- Reset asserted mid-frame: state and outputs return to reset values immediately. The partially written RAM is not cleared; `booting` stays high, so the CPU never sees it.
- Back-to-back `rx_valid` on consecutive cycles must be handled without loss.

## Test plan
- Nominal load, `LOAD_BASE=16'h0400`: bytes A5 03 00 11 22 33 9A -> writes 11@0400, 22@0401, 33@0402, each with a one-cycle `boot_we`; `boot_done=1`, `booting=0` one cycle after byte 9A.
- Garbage before sync: 00 FF 5A, then the nominal frame -> no `boot_we` before A5; result identical to the nominal load.
- Bad checksum: A5 01 00 7F 00 -> one write 7F@0400, `boot_error=1`, `booting` and `cpu_reset` remain 1; later bytes cause no writes.
- Zero length and overflow: A5 00 00 00 -> `boot_done=1` with no writes. After reset with `LOAD_BASE=16'hFF00`, A5 01 01 -> `boot_error` after the second length byte.
- Timeout with `TIMEOUT=100`: A5 02 00 11, then idle for 100 clocks -> `boot_error`. A second run sends the next byte exactly on the expiry cycle -> it is accepted with no error.
- Back-to-back and reset mid-frame: stream 256 bytes with `rx_valid` high continuously -> 256 sequential writes with no skips. Asserting `rst` mid-payload returns all outputs to reset values asynchronously, and a fresh frame then loads correctly.
